// File: rtl/mux_arb_pkg.sv
// Shared constants and helpers for the N-channel registered mux/arbiter.
package mux_arb_pkg;

   localparam logic MODE_DIRECT = 1'b0;
   localparam logic MODE_RR     = 1'b1;

   // Index width for n channels, never narrower than one bit
   function automatic int clog2(input int n);
      int r;
      r = 0;
      for (int v = n - 1; v > 0; v = v >> 1) r++;
      return (r < 1) ? 1 : r;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: rotate requests so ptr sits at bit 0,
// pick the lowest set bit, then rotate the index back.
module rr_arbiter
   import mux_arb_pkg::*;
#(
   parameter  int NUM_CH = 4,
   localparam int SEL_W  = clog2(NUM_CH)
) (
   input  logic [NUM_CH-1:0] req,
   input  logic [SEL_W-1:0]  ptr,
   output logic [SEL_W-1:0]  gnt_idx,
   output logic              gnt_any
);

   logic [NUM_CH-1:0] rot;
   logic [SEL_W-1:0]  k;
   logic [SEL_W:0]    sum;

   // Rotate, priority-encode from ptr, and unrotate the winning index
   always_comb begin
      rot     = '0;
      k       = '0;
      gnt_any = 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
         int idx;
         idx = i + int'(ptr);
         if (idx >= NUM_CH) idx = idx - NUM_CH;
         rot[i] = req[idx];
      end
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         if (rot[i]) begin
            k       = SEL_W'(i);
            gnt_any = 1'b1;
         end
      end
      sum = {1'b0, ptr} + {1'b0, k};
      if (sum >= (SEL_W+1)'(NUM_CH)) sum = sum - (SEL_W+1)'(NUM_CH);
      gnt_idx = sum[SEL_W-1:0];
   end

endmodule

// File: rtl/mux_arb_n.sv
// N-channel registered mux with valid/ready handshake; channel picked
// directly by sel or by round-robin arbitration over valid inputs.
module mux_arb_n
   import mux_arb_pkg::*;
#(
   parameter  int NUM_CH = 4,
   parameter  int DATA_W = 8,
   localparam int SEL_W  = clog2(NUM_CH)
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     mode,
   input  logic [SEL_W-1:0]         sel,
   input  logic [NUM_CH-1:0]        in_valid,
   input  logic [NUM_CH*DATA_W-1:0] in_data,
   output logic [NUM_CH-1:0]        in_ready,
   output logic                     out_valid,
   output logic [DATA_W-1:0]        out_data,
   output logic [SEL_W-1:0]         out_ch,
   input  logic                     out_ready
);

   logic [SEL_W-1:0]  rr_ptr;
   logic [SEL_W-1:0]  rr_idx;
   logic              rr_any;
   logic [SEL_W-1:0]  g;
   logic              gnt_any;
   logic              load;
   logic              xfer;
   logic [DATA_W-1:0] gdata;
   logic [SEL_W-1:0]  ptr_inc;

   rr_arbiter #(.NUM_CH(NUM_CH)) u_rr (
      .req     (in_valid),
      .ptr     (rr_ptr),
      .gnt_idx (rr_idx),
      .gnt_any (rr_any)
   );

   // Grant selection; a direct sel outside the channel range matches nothing
   always_comb begin
      g       = '0;
      gnt_any = 1'b0;
      if (mode == MODE_RR) begin
         g       = rr_idx;
         gnt_any = rr_any;
      end else begin
         for (int k = 0; k < NUM_CH; k++) begin
            if (sel == SEL_W'(k) && in_valid[k]) begin
               g       = SEL_W'(k);
               gnt_any = 1'b1;
            end
         end
      end
   end

   // Ready decode and winning-data mux; reset forces ready low
   always_comb begin
      load     = ~out_valid | out_ready;
      xfer     = gnt_any & load & rst_n;
      in_ready = '0;
      gdata    = '0;
      for (int k = 0; k < NUM_CH; k++) begin
         in_ready[k] = xfer && (g == SEL_W'(k));
         if (g == SEL_W'(k)) gdata = in_data[k*DATA_W +: DATA_W];
      end
      ptr_inc = (g == SEL_W'(NUM_CH - 1)) ? '0 : g + SEL_W'(1);
   end

   // Output register and round-robin pointer
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_ch    <= '0;
         rr_ptr    <= '0;
      end else begin
         if (xfer) begin
            out_valid <= 1'b1;
            out_data  <= gdata;
            out_ch    <= g;
            if (mode == MODE_RR) rr_ptr <= ptr_inc;
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule
